// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until mem_ready_i is high.
module mc_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int ZEXT_LOGIC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [5:0]            op_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  pc_write_o,
  output logic                  iord_o,
  output logic                  ir_write_o,
  output logic                  mem_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            reg_dst_o,
  output logic [1:0]            mem_to_reg_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [1:0]            pc_src_o,
  output logic                  imm_zext_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  illegal_o,
  output logic [3:0]            state_dbg_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_JR, S_JAL, S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = ALU_CTRL_W'(9);

  state_t                  r_state;
  logic                    w_mem_ok;
  logic                    w_r_legal;
  logic [ALU_CTRL_W-1:0]   w_r_alu;
  logic [ALU_CTRL_W-1:0]   w_imm_alu;
  logic                    w_zext_op;

`ifdef MC_MEM_WAIT_EN
  assign w_mem_ok = mem_ready_i;
`else
  logic w_unused;
  assign w_unused = mem_ready_i;
  assign w_mem_ok = 1'b1;
`endif

  // R-type function decode; anything not listed is flagged as illegal in EXEC.
  always_comb begin
    w_r_legal = 1'b1;
    w_r_alu   = ALU_ADD;
    case (funct_i)
      6'b100000, 6'b100001: w_r_alu = ALU_ADD;
      6'b100010, 6'b100011: w_r_alu = ALU_SUB;
      6'b100100:            w_r_alu = ALU_AND;
      6'b100101:            w_r_alu = ALU_OR;
      6'b101010:            w_r_alu = ALU_SLT;
      6'b000000:            w_r_alu = ALU_SLL;
      6'b000010:            w_r_alu = ALU_SRL;
      6'b000011:            w_r_alu = ALU_SRA;
      default:              w_r_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_imm_alu = ALU_ADD;
    case (op_i)
      OP_SLTI: w_imm_alu = ALU_SLT;
      OP_ANDI: w_imm_alu = ALU_AND;
      OP_ORI:  w_imm_alu = ALU_OR;
      default: w_imm_alu = ALU_ADD;
    endcase
  end

  assign w_zext_op   = (ZEXT_LOGIC != 0) && ((op_i == OP_ANDI) || (op_i == OP_ORI));
  assign state_dbg_o = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (w_mem_ok) r_state <= S_DECODE;
        S_DECODE: begin
          case (op_i)
            OP_LW, OP_SW:                       r_state <= S_MEMADR;
            OP_RTYPE:                           r_state <= (funct_i == F_JR) ? S_JR : S_EXEC;
            OP_BEQ, OP_BNE:                     r_state <= S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  r_state <= S_IMMEX;
            OP_J:                               r_state <= S_JUMP;
            OP_JAL:                             r_state <= S_JAL;
            default:                            r_state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: r_state <= (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (w_mem_ok) r_state <= S_MEMWB;
        S_MEMWR:  if (w_mem_ok) r_state <= S_FETCH;
        S_EXEC:   r_state <= w_r_legal ? S_ALUWB : S_ILLEGAL;
        S_IMMEX:  r_state <= S_IMMWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; reset overrides the state so no strobe fires on the reset cycle.
  always_comb begin
    pc_write_o    = 1'b0;
    iord_o        = 1'b0;
    ir_write_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = 2'd0;
    mem_to_reg_o  = 2'd0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'd0;
    pc_src_o      = 2'd0;
    imm_zext_o    = 1'b0;
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_FETCH: begin
          ir_write_o  = w_mem_ok;
          pc_write_o  = w_mem_ok;
          alu_src_b_o = 2'd1;
        end
        S_DECODE: alu_src_b_o = 2'd3;
        S_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
        end
        S_MEMRD: iord_o = 1'b1;
        S_MEMWB: begin
          mem_to_reg_o = 2'd1;
          reg_write_o  = 1'b1;
        end
        S_MEMWR: begin
          iord_o      = 1'b1;
          mem_write_o = w_mem_ok;
        end
        S_EXEC: begin
          alu_src_a_o   = 1'b1;
          alu_control_o = w_r_alu;
        end
        S_ALUWB: begin
          reg_dst_o   = 2'd1;
          reg_write_o = 1'b1;
        end
        S_IMMEX: begin
          alu_src_a_o   = 1'b1;
          alu_src_b_o   = 2'd2;
          alu_control_o = w_imm_alu;
          imm_zext_o    = w_zext_op;
        end
        S_IMMWB: begin
          reg_write_o = 1'b1;
          imm_zext_o  = w_zext_op;
        end
        S_BRANCH: begin
          alu_src_a_o   = 1'b1;
          alu_control_o = ALU_SUB;
          pc_src_o      = 2'd1;
          pc_write_o    = (op_i == OP_BNE) ? ~zero_i : zero_i;
        end
        S_JUMP: begin
          pc_src_o   = 2'd2;
          pc_write_o = 1'b1;
        end
        S_JR: begin
          pc_src_o   = 2'd3;
          pc_write_o = 1'b1;
        end
        S_JAL: begin
          pc_src_o     = 2'd2;
          pc_write_o   = 1'b1;
          reg_dst_o    = 2'd2;
          mem_to_reg_o = 2'd2;
          reg_write_o  = 1'b1;
        end
        S_ILLEGAL: illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
